// File: rtl/pulse_input_conditioner_pkg.sv
// Purpose: shared types and constants for the pulse-mode input conditioner.
//   - state_e   : arbitration FSM states
//   - btn_vec_t : one bit per button, [2]=x1, [1]=x2, [0]=x3
//   - prio_pick : fixed-priority one-hot pick, x1 > x2 > x3
package pulse_cond_pkg;

    localparam int unsigned N_BTN = 3;

    localparam int unsigned X1_IDX = 2;
    localparam int unsigned X2_IDX = 1;
    localparam int unsigned X3_IDX = 0;

    // 20 ms at 100 MHz on the board; a short window keeps simulation fast
    localparam int unsigned DB_CYCLES_BOARD = 2_000_000;
    localparam int unsigned DB_CYCLES_SIM   = 4;
    localparam int unsigned CNT_W_BOARD     = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef logic [N_BTN-1:0] btn_vec_t;

    // One-hot winner among simultaneous requests
    function automatic btn_vec_t prio_pick(input btn_vec_t req);
        btn_vec_t grant;
        grant = '0;
        if (req[X1_IDX]) begin
            grant[X1_IDX] = 1'b1;
        end else if (req[X2_IDX]) begin
            grant[X2_IDX] = 1'b1;
        end else if (req[X3_IDX]) begin
            grant[X3_IDX] = 1'b1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/pulse_input_conditioner_if.sv
// Purpose: button-side bus of the pulse input conditioner.
//   btn_raw   : raw bouncing button levels
//   clr_err   : synchronous clear of the collision flag
//   x_pulse   : one-hot output pulses
//   busy      : high while a pulse is being emitted
//   collision : sticky flag for dropped presses
//   btn_db    : debounced levels for LEDs
// master drives buttons and observes outputs; slave is the conditioner.
interface pulse_input_conditioner_if;
    import pulse_cond_pkg::*;

    btn_vec_t btn_raw;
    logic     clr_err;
    btn_vec_t x_pulse;
    logic     busy;
    logic     collision;
    btn_vec_t btn_db;

    modport master (
        output btn_raw,
        output clr_err,
        input  x_pulse,
        input  busy,
        input  collision,
        input  btn_db
    );

    modport slave (
        input  btn_raw,
        input  clr_err,
        output x_pulse,
        output busy,
        output collision,
        output btn_db
    );

endinterface

// File: rtl/pulse_input_conditioner_btn_debounce.sv
// Purpose: single-button front end: 2-flop synchronizer, debounce counter
// and rising-edge detect.
//   clk, rst : clock, asynchronous active-high reset
//   raw      : asynchronous bouncing level
//   db       : debounced level (registered)
//   rise_c   : one-cycle rising edge of db (combinational from flops)
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise_c
);

    logic             sync1_q, sync1_d;
    logic             s_q, s_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state: synchronizer shift, debounce count, edge-detect delay
    always_comb begin
        sync1_d  = raw;
        s_d      = sync1_q;
        db_d     = db_q;
        cnt_d    = '0;
        db_dly_d = db_q;
        // Any cycle where s agrees with db restarts the stability window
        if (s_q != db_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                db_d  = s_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            s_q      <= s_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            cnt_q    <= cnt_d;
        end
    end

    assign db     = db_q;
    assign rise_c = db_q & ~db_dly_q;

endmodule

// File: rtl/pulse_input_conditioner.sv
// Purpose: turns three bouncing buttons into clean, mutually exclusive
// single pulses x1/x2/x3 for the pulse-mode state logic.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pulse_input_conditioner_if
//              (btn_raw, clr_err in; x_pulse, busy, collision, btn_db out)
module pulse_input_conditioner
    import pulse_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES    = DB_CYCLES_BOARD,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned CNT_W        = CNT_W_BOARD
) (
    input  logic                        clk,
    input  logic                        rst,
    pulse_input_conditioner_if.slave    bus
);

    localparam int unsigned PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    btn_vec_t          db;
    btn_vec_t          rise_c;
    btn_vec_t          held_c;
    btn_vec_t          win_c;
    logic              col_set_c;

    state_e            state_q, state_d;
    btn_vec_t          x_pulse_q, x_pulse_d;
    logic              busy_q, busy_d;
    logic              collision_q, collision_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    // Per-button synchronize, debounce and rise detect
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .raw    (bus.btn_raw[i]),
            .db     (db[i]),
            .rise_c (rise_c[i])
        );
    end

    // Arbitration, lockout and pulse FSM
    always_comb begin
        state_d   = state_q;
        x_pulse_d = x_pulse_q;
        busy_d    = busy_q;
        pcnt_d    = pcnt_q;
        col_set_c = 1'b0;
        // Buttons already held before this cycle; rising ones are excluded so
        // a true simultaneous press is arbitrated rather than locked out
        held_c    = db & ~rise_c;
        win_c     = prio_pick(rise_c);

        unique case (state_q)
            ST_IDLE: begin
                if (rise_c != '0) begin
                    if (((rise_c & (rise_c - btn_vec_t'(1))) != '0) || (held_c != '0)) begin
                        col_set_c = 1'b1;
                    end
                    if (held_c == '0) begin
                        state_d   = ST_EMIT;
                        x_pulse_d = win_c;
                        busy_d    = 1'b1;
                        pcnt_d    = PCNT_W'(PULSE_CYCLES - 1);
                    end
                end
            end
            ST_EMIT: begin
                if (rise_c != '0) begin
                    col_set_c = 1'b1;
                end
                if (pcnt_q == '0) begin
                    state_d   = ST_GAP;
                    x_pulse_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    pcnt_d = pcnt_q - PCNT_W'(1);
                end
            end
            ST_GAP: begin
                if (rise_c != '0) begin
                    col_set_c = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                x_pulse_d = '0;
                busy_d    = 1'b0;
            end
        endcase

        // Setting wins over a same-cycle clear
        if (col_set_c) begin
            collision_d = 1'b1;
        end else if (bus.clr_err) begin
            collision_d = 1'b0;
        end else begin
            collision_d = collision_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_pulse_q   <= '0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
            pcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_pulse_q   <= x_pulse_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign bus.x_pulse   = x_pulse_q;
    assign bus.busy      = busy_q;
    assign bus.collision = collision_q;
    assign bus.btn_db    = db;

endmodule
